// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op encodings, FSM state type and default datapath width.
package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mduState_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitudes and result sign correction for signed ops.
// Divide handling is present only when MDU_DIVIDE_EN is defined.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] rawHi,
    input  logic [DATA_WIDTH-1:0] rawLo,
    output logic [DATA_WIDTH-1:0] aMag,
    output logic [DATA_WIDTH-1:0] bMag,
    output logic [DATA_WIDTH-1:0] resHi,
    output logic [DATA_WIDTH-1:0] resLo
);

    logic                      isSigned;
    logic                      aNeg;
    logic                      bNeg;
    logic [2*DATA_WIDTH-1:0]   prod;

    always_comb begin
        isSigned = (op == OP_MULT) || (op == OP_DIV);
        aNeg     = isSigned && a[DATA_WIDTH-1];
        bNeg     = isSigned && b[DATA_WIDTH-1];
        // Most-negative maps to itself, which is the right unsigned magnitude.
        aMag     = aNeg ? (~a + 1'b1) : a;
        bMag     = bNeg ? (~b + 1'b1) : b;
        prod     = {rawHi, rawLo};
        if (aNeg ^ bNeg) begin
            prod = ~prod + 1'b1;
        end
        {resHi, resLo} = prod;
`ifdef MDU_DIVIDE_EN
        if (op[1]) begin
            if (b == '0) begin
                resLo = '1;
                resHi = a;
            end else begin
                resLo = (aNeg ^ bNeg) ? (~rawLo + 1'b1) : rawLo;
                resHi = aNeg ? (~rawHi + 1'b1) : rawHi;
            end
        end
`endif
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 HI/LO multiply/divide unit, one step per cycle.
// Divide datapath is built only when MDU_DIVIDE_EN is defined.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic                  writeHi,
    input  logic                  writeLo,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CW = $clog2(DATA_WIDTH);
`ifdef MDU_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    mduState_t             state;
    logic [1:0]            opReg;
    logic [DATA_WIDTH-1:0] aReg;
    logic [DATA_WIDTH-1:0] bReg;
    logic [DATA_WIDTH-1:0] pHi;
    logic [DATA_WIDTH-1:0] pLo;
    logic [CW-1:0]         count;

    logic [DATA_WIDTH-1:0] aMag;
    logic [DATA_WIDTH-1:0] bMag;
    logic [DATA_WIDTH-1:0] resHi;
    logic [DATA_WIDTH-1:0] resLo;
    logic [DATA_WIDTH-1:0] curHi;
    logic [DATA_WIDTH-1:0] curLo;
    logic [DATA_WIDTH-1:0] stepHi;
    logic [DATA_WIDTH-1:0] stepLo;
    logic [DATA_WIDTH:0]   sum;
`ifdef MDU_DIVIDE_EN
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
`endif

    mdu_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) signFix (
        .op    (opReg),
        .a     (aReg),
        .b     (bReg),
        .rawHi (stepHi),
        .rawLo (stepLo),
        .aMag  (aMag),
        .bMag  (bMag),
        .resHi (resHi),
        .resLo (resLo)
    );

    // The first step seeds the working pair from the magnitudes.
    always_comb begin
        curHi  = (count == '0) ? '0 : pHi;
        curLo  = pLo;
        if (count == '0) begin
            curLo = opReg[1] ? aMag : bMag;
        end
        sum    = {1'b0, curHi} + (curLo[0] ? {1'b0, aMag} : '0);
        stepHi = sum[DATA_WIDTH:1];
        stepLo = {sum[0], curLo[DATA_WIDTH-1:1]};
`ifdef MDU_DIVIDE_EN
        shifted = {curHi, curLo[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, bMag};
        if (opReg[1]) begin
            stepHi = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0]
                                       : trial[DATA_WIDTH-1:0];
            stepLo = {curLo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            opReg <= '0;
            aReg  <= '0;
            bReg  <= '0;
            pHi   <= '0;
            pLo   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (writeHi) hi <= writeData;
                    if (writeLo) lo <= writeData;
                    if (start) begin
                        opReg <= op;
                        aReg  <= opA;
                        bReg  <= opB;
                        count <= '0;
                        if (op[1] && !DIV_EN) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    pHi   <= stepHi;
                    pLo   <= stepLo;
                    count <= count + 1'b1;
                    if (count == CW'(DATA_WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= resHi;
                        lo    <= resLo;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
